// File: rtl/pong_pkg.sv
// Shared pong board constants and the ball state encoding.
package pong_pkg;

  localparam int unsigned BOARD_WIDTH   = 40;
  localparam int unsigned BOARD_HEIGHT  = 30;
  localparam int unsigned PADDLE_HEIGHT = 6;
  localparam int unsigned TILE_W        = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SCORED
  } ball_state_e;

endpackage

// File: rtl/pong_tick_gen.sv
// Rate counter: o_tick is high for one cycle every PERIOD enabled cycles.
module pong_tick_gen #(
  parameter int unsigned PERIOD = 1250000
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_enable,
  output logic o_tick
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt;
  logic          last;

  assign last   = (cnt == CW'(PERIOD - 1));
  assign o_tick = i_enable && last;

  // Disabled means held at zero, so every enable starts a full period.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (!i_enable || last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pong_ball.sv
// Ball engine: moves the ball per tick, reflects off walls and paddles,
// pulses a score on a miss and draws the ball tile for the renderer.
module pong_ball #(
  parameter int unsigned BOARD_WIDTH   = pong_pkg::BOARD_WIDTH,
  parameter int unsigned BOARD_HEIGHT  = pong_pkg::BOARD_HEIGHT,
  parameter int unsigned PADDLE_HEIGHT = pong_pkg::PADDLE_HEIGHT,
  parameter int unsigned BALL_SPEED    = 1250000
) (
  input  logic                        clk,
  input  logic                        i_rst_n,
  input  logic                        i_game_active,
  input  logic [pong_pkg::TILE_W-1:0] i_paddle1_y,
  input  logic [pong_pkg::TILE_W-1:0] i_paddle2_y,
  input  logic [pong_pkg::TILE_W-1:0] i_col_counter_div,
  input  logic [pong_pkg::TILE_W-1:0] i_row_counter_div,
  output logic [pong_pkg::TILE_W-1:0] o_ball_x,
  output logic [pong_pkg::TILE_W-1:0] o_ball_y,
  output logic                        o_draw,
  output logic                        o_p1_score,
  output logic                        o_p2_score
);

  import pong_pkg::*;

  localparam logic [TILE_W-1:0] X_CTR = TILE_W'(BOARD_WIDTH / 2);
  localparam logic [TILE_W-1:0] Y_CTR = TILE_W'(BOARD_HEIGHT / 2);
  localparam logic [TILE_W-1:0] X_MIN = TILE_W'(1);
  localparam logic [TILE_W-1:0] X_MAX = TILE_W'(BOARD_WIDTH - 2);
  localparam logic [TILE_W-1:0] Y_MAX = TILE_W'(BOARD_HEIGHT - 1);

  ball_state_e       state, state_n;
  logic [TILE_W-1:0] x, y, x_n, y_n;
  logic              dx, dy, dx_n, dy_n;
  logic              p1s_n, p2s_n;
  logic              tick;

  pong_tick_gen #(.PERIOD(BALL_SPEED)) u_tick (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_enable (state == RUN),
    .o_tick   (tick)
  );

  // Range check widened by one bit so top + PADDLE_HEIGHT-1 cannot wrap.
  function automatic logic paddle_hit(input logic [TILE_W-1:0] top,
                                      input logic [TILE_W-1:0] ball);
    logic [TILE_W:0] t, b;
    t = {1'b0, top};
    b = {1'b0, ball};
    return (b >= t) && (b <= t + (TILE_W + 1)'(PADDLE_HEIGHT - 1));
  endfunction

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    dx_n    = dx;
    dy_n    = dy;
    p1s_n   = 1'b0;
    p2s_n   = 1'b0;
    case (state)
      IDLE: begin
        x_n = X_CTR;
        y_n = Y_CTR;
        if (i_game_active) state_n = RUN;
      end
      RUN: begin
        if (!i_game_active) begin
          state_n = IDLE;
          x_n     = X_CTR;
          y_n     = Y_CTR;
          dy_n    = 1'b1;
        end else if (tick) begin
          if (y == '0 && !dy) begin
            dy_n = 1'b1;
            y_n  = TILE_W'(1);
          end else if (y == Y_MAX && dy) begin
            dy_n = 1'b0;
            y_n  = Y_MAX - TILE_W'(1);
          end else begin
            y_n = dy ? y + TILE_W'(1) : y - TILE_W'(1);
          end

          if (x == X_MIN && !dx) begin
            if (paddle_hit(i_paddle1_y, y)) begin
              dx_n = 1'b1;
              x_n  = X_MIN + TILE_W'(1);
            end else begin
              state_n = SCORED;
              p2s_n   = 1'b1;
              dx_n    = 1'b0;
            end
          end else if (x == X_MAX && dx) begin
            if (paddle_hit(i_paddle2_y, y)) begin
              dx_n = 1'b0;
              x_n  = X_MAX - TILE_W'(1);
            end else begin
              state_n = SCORED;
              p1s_n   = 1'b1;
              dx_n    = 1'b1;
            end
          end else begin
            x_n = dx ? x + TILE_W'(1) : x - TILE_W'(1);
          end
        end
      end
      SCORED: begin
        state_n = IDLE;
        x_n     = X_CTR;
        y_n     = Y_CTR;
        dy_n    = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      x          <= X_CTR;
      y          <= Y_CTR;
      dx         <= 1'b1;
      dy         <= 1'b1;
      o_p1_score <= 1'b0;
      o_p2_score <= 1'b0;
      o_draw     <= 1'b0;
    end else begin
      state      <= state_n;
      x          <= x_n;
      y          <= y_n;
      dx         <= dx_n;
      dy         <= dy_n;
      o_p1_score <= p1s_n;
      o_p2_score <= p2s_n;
      o_draw     <= (state != SCORED) && (i_col_counter_div == x) &&
                    (i_row_counter_div == y);
    end
  end

  assign o_ball_x = x;
  assign o_ball_y = y;

endmodule

// File: tb/tb_pong_ball.sv
// Scoreboard bench for pong_ball with BALL_SPEED=4: stimulus queues expected
// output vectors by cycle, a negedge monitor pops and compares them.
module tb_pong_ball;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       act = 1'b0;
  logic [5:0] p1y, p2y, trk, p1_fix;
  logic       trk1;
  logic [5:0] col, row;
  logic [5:0] bx, by;
  logic       draw, p1s, p2s;

  pong_ball #(.BALL_SPEED(4)) dut (
    .clk               (clk),
    .i_rst_n           (rst_n),
    .i_game_active     (act),
    .i_paddle1_y       (p1y),
    .i_paddle2_y       (p2y),
    .i_col_counter_div (col),
    .i_row_counter_div (row),
    .o_ball_x          (bx),
    .o_ball_y          (by),
    .o_draw            (draw),
    .o_p1_score        (p1s),
    .o_p2_score        (p2s)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Tracking paddles are stimulus only: they centre themselves on the ball.
  always_comb begin
    trk = (by >= 6'd2) ? by - 6'd2 : 6'd0;
    p1y = trk1 ? trk : p1_fix;
    p2y = trk;
  end

  typedef struct {
    int unsigned cyc;
    logic [5:0]  x, y;
    logic        d, s1, s2;
    bit          pos;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void push(int unsigned c, int x, int y, bit d, bit s1,
                               bit s2, bit pos, string nm);
    exp_t e;
    int   i;
    e.cyc = c; e.x = 6'(x); e.y = 6'(y);
    e.d = d; e.s1 = s1; e.s2 = s2; e.pos = pos; e.nm = nm;
    i = q.size();
    while (i > 0 && q[i-1].cyc > c) i--;
    q.insert(i, e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: due at cycle %0d, reached at %0d", e.nm, e.cyc, cyc);
      end else if ((e.pos && (bx != e.x || by != e.y)) || draw != e.d ||
                   p1s != e.s1 || p2s != e.s2) begin
        errors++;
        $display("FAIL %s @%0d: got x=%0d y=%0d draw=%b p1=%b p2=%b; want x=%0d y=%0d draw=%b p1=%b p2=%b (pos %s)",
                 e.nm, cyc, bx, by, draw, p1s, p2s, e.x, e.y, e.d, e.s1, e.s2,
                 e.pos ? "checked" : "ignored");
      end
    end
  end

  task automatic step(int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    act   = 1'b0;
    step(2);
    rst_n = 1'b1;
    push(cyc, 20, 15, 0, 0, 0, 1, "reset_values");
  endtask

  initial begin
    int unsigned n, s;
    int unsigned tt[12] = '{1, 2, 14, 15, 18, 19, 43, 44, 55, 56, 1609, 1610};
    int          xs[12] = '{21, 22, 34, 35, 38, 37, 13, 12, 1, 2, 1, 2};
    int          ys[12] = '{16, 17, 29, 28, 25, 24, 0, 1, 12, 13, 0, 1};
    int          dc[7]  = '{20, 20, 19, 21, 20, 20, 63};
    int          dr[7]  = '{15, 14, 15, 15, 16, 15, 63};
    int          pv[4]  = '{12, 7, 6, 13};
    exp_t        e;

    col = 6'd63; row = 6'd63; p1_fix = 6'd0; trk1 = 1'b1;
    do_reset();

    // Draw only on the ball tile, one cycle after the scan position.
    for (int i = 0; i < 7; i++) begin
      col = 6'(dc[i]);
      row = 6'(dr[i]);
      push(cyc + 1, 20, 15, (dc[i] == 20 && dr[i] == 15), 0, 0, 1, "draw");
      step(1);
    end
    push(cyc + 8, 20, 15, 0, 0, 0, 1, "idle_hold");
    step(9);

    // Long rally with tracking paddles: walls, paddle hits, then the corner.
    n = cyc;
    act = 1'b1;
    push(n + 4, 20, 15, 0, 0, 0, 1, "no_early_move");
    for (int i = 0; i < 12; i++)
      push(n + 1 + 4 * tt[i], xs[i], ys[i], 0, 0, 0, 1, "rally");
    wait_until(n + 2 + 4 * 1610);

    // Paddle 1 edges, ball arriving at x=1 with y=12.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      trk1 = 1'b0;
      p1_fix = 6'(pv[i]);
      n = cyc;
      act = 1'b1;
      s = n + 1 + 4 * 56;
      push(s - 4, 1, 12, 0, 0, 0, 1, "p1_approach");
      if (i < 2) begin
        push(s, 2, 13, 0, 0, 0, 1, "p1_hit");
        wait_until(s + 1);
      end else if (i == 2) begin
        push(s, 0, 0, 0, 0, 1, 0, "p2_score_pulse");
        push(s + 1, 20, 15, 0, 0, 0, 1, "recentre_after_score");
        push(s + 5, 20, 15, 0, 0, 0, 1, "serve_wait");
        push(s + 6, 19, 16, 0, 0, 0, 1, "serve_left");
        wait_until(s + 7);
      end else begin
        wait_until(s);
        #1;
        rst_n = 1'b0;
        push(cyc, 20, 15, 0, 0, 0, 1, "reset_drops_pulse");
        step(2);
      end
      trk1 = 1'b1;
    end

    // Reset asserted mid-RUN.
    do_reset();
    n = cyc;
    act = 1'b1;
    push(n + 5, 21, 16, 0, 0, 0, 1, "pre_reset_move");
    wait_until(n + 6);
    #1;
    rst_n = 1'b0;
    push(cyc, 20, 15, 0, 0, 0, 1, "reset_mid_run");
    step(2);

    // game_active dropped mid-RUN: recentre, no pulse, counter restarts at 0.
    do_reset();
    n = cyc;
    act = 1'b1;
    push(n + 9, 22, 17, 0, 0, 0, 1, "pre_drop");
    wait_until(n + 10);
    act = 1'b0;
    push(n + 11, 20, 15, 0, 0, 0, 1, "drop_recentre");
    push(n + 12, 20, 15, 0, 0, 0, 1, "drop_no_score");
    wait_until(n + 12);
    act = 1'b1;
    push(n + 16, 20, 15, 0, 0, 0, 1, "restart_wait");
    push(n + 17, 21, 16, 0, 0, 0, 1, "restart_move");
    wait_until(n + 18);

    step(4);
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never compared (due cycle %0d, now %0d)", e.nm, e.cyc, cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
